// File: rtl/cache_line_refill_pkg.sv
// Shared constants and refill FSM encoding for the cache line refill stage.
package cache_line_refill_pkg;

    localparam int CACHE_LINE_SIZE = 16;
    localparam int WORD_BYTES      = 4;

    typedef enum logic [2:0] {
        RF_IDLE    = 3'd0,
        RF_WB_REQ  = 3'd1,
        RF_RD_REQ  = 3'd2,
        RF_RD_WAIT = 3'd3,
        RF_DONE    = 3'd4
    } rf_state_e;

endpackage

// File: rtl/cache_line_refill_line_word_buf.sv
// Line-wide register written one 32-bit word at a time, read as a whole line.
module line_word_buf #(
    parameter int WORDS = 4,
    parameter int CNT_W = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [CNT_W-1:0]      idx,
    input  logic [31:0]           wdata,
    output logic [WORDS*32-1:0]   line
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line <= '0;
        end else if (we) begin
            line[idx*32 +: 32] <= wdata;
        end
    end

endmodule

// File: rtl/cache_line_refill.sv
// Miss handler: optional dirty-victim write-back, then a word-by-word line fetch
// over a req/gnt bus, delivered to the cache with a one-cycle fill strobe.
module cache_line_refill
    import cache_line_refill_pkg::*;
#(
    parameter int LINE_BYTES = CACHE_LINE_SIZE,
    parameter int ADDR_W     = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic                    req_dirty,
    input  logic [ADDR_W-1:0]       victim_addr,
    input  logic [LINE_BYTES*8-1:0] victim_data,
    output logic                    fill_valid,
    output logic [ADDR_W-1:0]       fill_addr,
    output logic [LINE_BYTES*8-1:0] fill_data,
    output logic                    busy,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [31:0]             mem_wdata,
    input  logic                    mem_gnt,
    input  logic                    mem_rvalid,
    input  logic [31:0]             mem_rdata
);

    localparam int WORDS = LINE_BYTES / WORD_BYTES;
    localparam int CNT_W = $clog2(WORDS);
    localparam logic [ADDR_W-1:0] BASE_MASK = ~ADDR_W'(LINE_BYTES - 1);
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(WORDS - 1);

    rf_state_e                state, state_nxt;
    logic [CNT_W-1:0]         cnt;
    logic                     cnt_clr, cnt_inc, buf_we, accept, last_word;
    logic [ADDR_W-1:0]        victim_base, fill_base, word_off;
    logic [LINE_BYTES*8-1:0]  victim_line;

    // Handshakes: a request transfers on the cycle req_valid && req_ready is high;
    // a bus beat transfers on the cycle mem_req && mem_gnt is high, and mem_req
    // with its address/data is held unchanged until then.
    assign req_ready = (state == RF_IDLE);
    assign busy      = !req_ready;
    assign accept    = req_valid && req_ready;
    assign last_word = (cnt == LAST_CNT);
    assign word_off  = {{(ADDR_W-CNT_W-2){1'b0}}, cnt, 2'b00};
    assign fill_addr = fill_base;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RF_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            victim_base <= '0;
            fill_base   <= '0;
            victim_line <= '0;
        end else begin
            if (cnt_clr) begin
                cnt <= '0;
            end else if (cnt_inc) begin
                cnt <= cnt + 1'b1;
            end
            if (accept) begin
                victim_base <= victim_addr & BASE_MASK;
                fill_base   <= req_addr & BASE_MASK;
                victim_line <= victim_data;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        buf_we     = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        fill_valid = 1'b0;
        case (state)
            RF_IDLE: begin
                if (req_valid) begin
                    cnt_clr   = 1'b1;
                    state_nxt = req_dirty ? RF_WB_REQ : RF_RD_REQ;
                end
            end
            RF_WB_REQ: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = victim_base + word_off;
                mem_wdata = victim_line[cnt*32 +: 32];
                if (mem_gnt) begin
                    if (last_word) begin
                        cnt_clr   = 1'b1;
                        state_nxt = RF_RD_REQ;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            RF_RD_REQ: begin
                mem_req  = 1'b1;
                mem_addr = fill_base + word_off;
                if (mem_gnt) begin
                    state_nxt = RF_RD_WAIT;
                end
            end
            RF_RD_WAIT: begin
                if (mem_rvalid) begin
                    buf_we = 1'b1;
                    if (last_word) begin
                        state_nxt = RF_DONE;
                    end else begin
                        cnt_inc   = 1'b1;
                        state_nxt = RF_RD_REQ;
                    end
                end
            end
            RF_DONE: begin
                fill_valid = 1'b1;
                state_nxt  = RF_IDLE;
            end
            default: state_nxt = RF_IDLE;
        endcase
    end

    line_word_buf #(
        .WORDS (WORDS),
        .CNT_W (CNT_W)
    ) u_fill_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (buf_we),
        .idx   (cnt),
        .wdata (mem_rdata),
        .line  (fill_data)
    );

endmodule
